// File: rtl/uart_rx_slave_pkg.sv
// rtl/uart_rx_slave_pkg.sv - register offsets, status/control bit positions and receiver states
package uart_rx_slave_pkg;

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_STAT = 2'd1;
  localparam logic [1:0] REG_CTRL = 2'd2;
  localparam logic [1:0] REG_RSVD = 2'd3;

  localparam int STAT_NOT_EMPTY = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_FRAME_ERR = 2;
  localparam int STAT_OVERRUN   = 3;
  localparam int STAT_COUNT_LSB = 8;

  localparam int CTRL_INT_EN  = 0;
  localparam int CTRL_ERR_CLR = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_slave_fifo.sv
// rtl/uart_rx_slave_fifo.sv - receive byte FIFO, power-of-2 depth, pointers wrap naturally
module uart_rx_slave_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     i_push,
  input  logic [W-1:0]             i_din,
  input  logic                     i_pop,
  output logic [W-1:0]             o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/uart_rx_slave.sv
// rtl/uart_rx_slave.sv - memory-mapped 8N1 UART receiver with byte FIFO and level interrupt
module uart_rx_slave
  import uart_rx_slave_pkg::*;
#(
  parameter int          CLK_FREQ   = 50_000_000,
  parameter int          BAUD       = 115_200,
  parameter int          OVERSAMPLE = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_4000,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] BUS_addr,
  inout  wire  [31:0] BUS_data,
  input  logic        BUS_req,
  output logic        BUS_ready,
  input  logic        BUS_RW,
  input  logic        RxD,
  output logic        rx_int
);

  localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int S_W   = $clog2(OVERSAMPLE);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]       r_sync;
  logic             r_rxd_prev;
  logic [DIV_W-1:0] r_div_cnt;
  rx_state_t        r_state, w_state_nxt;
  logic [S_W-1:0]   r_s, w_s_nxt;
  logic [2:0]       r_bit, w_bit_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic             w_push, w_ferr_set;
  logic             w_rxd, w_fall, w_tick;
  logic             r_ready, r_int_en, r_overrun, r_frame_err;
  logic [31:0]      r_rdata, w_rdata;
  logic             w_sel, w_rise, w_pop, w_ctrl_wr, w_err_clr;
  logic [7:0]       w_head;
  logic             w_full, w_empty;
  logic [CNT_W-1:0] w_count;
  logic             w_unused_bus;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_sync     <= 2'b11;
      r_rxd_prev <= 1'b1;
    end else begin
      r_sync     <= {r_sync[0], RxD};
      r_rxd_prev <= r_sync[1];
    end
  end

  assign w_rxd  = r_sync[1];
  assign w_fall = r_rxd_prev & ~w_rxd;
  assign w_tick = (r_div_cnt == '0);

  always_ff @(posedge clk) begin
    if (clr || w_tick) r_div_cnt <= DIV_W'(DIV - 1);
    else               r_div_cnt <= r_div_cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= ST_IDLE;
      r_s     <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_s     <= w_s_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // Start bit is checked at mid-bit; every later sample is a full bit period on.
  always_comb begin
    w_state_nxt = r_state;
    w_s_nxt     = r_s;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_push      = 1'b0;
    w_ferr_set  = 1'b0;
    case (r_state)
      ST_IDLE: if (w_fall) begin
        w_state_nxt = ST_START;
        w_s_nxt     = '0;
      end
      ST_START: if (w_tick) begin
        if (r_s == S_W'(OVERSAMPLE/2 - 1)) begin
          w_s_nxt     = '0;
          w_bit_nxt   = '0;
          w_state_nxt = w_rxd ? ST_IDLE : ST_DATA;
        end else w_s_nxt = r_s + 1'b1;
      end
      ST_DATA: if (w_tick) begin
        if (r_s == S_W'(OVERSAMPLE - 1)) begin
          w_s_nxt     = '0;
          w_shift_nxt = {w_rxd, r_shift[7:1]};
          w_bit_nxt   = r_bit + 1'b1;
          if (r_bit == 3'd7) w_state_nxt = ST_STOP;
        end else w_s_nxt = r_s + 1'b1;
      end
      ST_STOP: if (w_tick) begin
        if (r_s == S_W'(OVERSAMPLE - 1)) begin
          w_s_nxt     = '0;
          w_state_nxt = ST_IDLE;
          w_push      = w_rxd;
          w_ferr_set  = ~w_rxd;
        end else w_s_nxt = r_s + 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  uart_rx_slave_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk     (clk),
    .clr     (clr),
    .i_push  (w_push),
    .i_din   (r_shift),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_sel     = BUS_req & (BUS_addr[31:2] == BASE_ADDR[31:2]);
  assign w_rise    = w_sel & ~r_ready;
  assign w_pop     = w_rise & ~BUS_RW & (BUS_addr[1:0] == REG_DATA) & ~w_empty;
  assign w_ctrl_wr = w_rise & BUS_RW & (BUS_addr[1:0] == REG_CTRL);
  assign w_err_clr = w_ctrl_wr & BUS_data[CTRL_ERR_CLR];

  always_comb begin
    w_rdata = '0;
    case (BUS_addr[1:0])
      REG_DATA: w_rdata = w_empty ? 32'd0 : {24'd0, w_head};
      REG_STAT: begin
        w_rdata[STAT_COUNT_LSB +: 8] = 8'(w_count);
        w_rdata[STAT_OVERRUN]        = r_overrun;
        w_rdata[STAT_FRAME_ERR]      = r_frame_err;
        w_rdata[STAT_FULL]           = w_full;
        w_rdata[STAT_NOT_EMPTY]      = ~w_empty;
      end
      REG_CTRL: w_rdata[CTRL_INT_EN] = r_int_en;
      default:  w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_ready <= 1'b0;
      r_rdata <= '0;
    end else if (w_rise) begin
      r_ready <= 1'b1;
      r_rdata <= w_rdata;
    end else if (!BUS_req) begin
      r_ready <= 1'b0;
    end
  end

  // Clearing the errors takes priority over a new error in the same cycle.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_int_en    <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_ctrl_wr) r_int_en <= BUS_data[CTRL_INT_EN];
      if (w_err_clr) begin
        r_overrun   <= 1'b0;
        r_frame_err <= 1'b0;
      end else begin
        if (w_ferr_set)                  r_frame_err <= 1'b1;
        if (w_push && w_full && !w_pop)  r_overrun   <= 1'b1;
      end
    end
  end

  assign BUS_ready    = w_sel ? r_ready : 1'bz;
  assign BUS_data     = (w_sel && !BUS_RW && r_ready) ? r_rdata : 32'hzzzz_zzzz;
  assign rx_int       = r_int_en & ~w_empty;
  assign w_unused_bus = &{1'b0, BUS_data[31:2]};

endmodule

// File: tb/tb_uart_rx_slave.sv
// tb/tb_uart_rx_slave.sv - directed bench for uart_rx_slave (DIV=1, 16 clocks per bit)
module tb_uart_rx_slave;
  import uart_rx_slave_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_4000;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [31:0] bus_addr = BASE;
  wire  [31:0] bus_data;
  logic        bus_req = 1'b0;
  logic        bus_rw = 1'b0;
  wire         bus_ready;
  logic        rxd = 1'b1;
  logic        rx_int;
  logic [31:0] wdata = '0;
  logic        wen = 1'b0;

  int total = 0;
  int bad = 0;

  assign bus_data = wen ? wdata : 32'hzzzz_zzzz;

  uart_rx_slave #(
    .CLK_FREQ(1_600_000), .BAUD(100_000), .OVERSAMPLE(16),
    .BASE_ADDR(BASE), .FIFO_DEPTH(16)
  ) dut (
    .clk(clk), .clr(clr), .BUS_addr(bus_addr), .BUS_data(bus_data),
    .BUS_req(bus_req), .BUS_ready(bus_ready), .BUS_RW(bus_rw),
    .RxD(rxd), .rx_int(rx_int)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus_ready !== 1'b1 && n < 32);
    if (bus_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: ready=%b required 1", name, bus_ready);
    end
  endtask

  task automatic bus_read(input logic [1:0] off, output logic [31:0] data);
    @(negedge clk);
    bus_addr = BASE + {30'd0, off};
    bus_rw   = 1'b0;
    bus_req  = 1'b1;
    wait_ready("bus_read");
    data    = bus_data;
    bus_req = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] off, input logic [31:0] data);
    @(negedge clk);
    bus_addr = BASE + {30'd0, off};
    bus_rw   = 1'b1;
    wdata    = data;
    wen      = 1'b1;
    bus_req  = 1'b1;
    wait_ready("bus_write");
    bus_req = 1'b0;
    wen     = 1'b0;
    bus_rw  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rxd = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (16) @(negedge clk);
    end
    rxd = stop;
    repeat (16) @(negedge clk);
    rxd = 1'b1;
  endtask

  typedef struct {
    string       name;
    logic        wr;
    logic [1:0]  off;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[13];
  logic [31:0] rd;
  int          rise_at;

  initial begin
    vecs[0]  = '{"rst_stat",       1'b0, REG_STAT, 32'h0, 32'h0};
    vecs[1]  = '{"rst_data_empty", 1'b0, REG_DATA, 32'h0, 32'h0};
    vecs[2]  = '{"rst_ctrl",       1'b0, REG_CTRL, 32'h0, 32'h0};
    vecs[3]  = '{"rst_rsvd",       1'b0, REG_RSVD, 32'h0, 32'h0};
    vecs[4]  = '{"wr_ctrl_1",      1'b1, REG_CTRL, 32'h1, 32'h0};
    vecs[5]  = '{"ctrl_int_en",    1'b0, REG_CTRL, 32'h0, 32'h1};
    vecs[6]  = '{"wr_rsvd",        1'b1, REG_RSVD, 32'hFFFF_FFFF, 32'h0};
    vecs[7]  = '{"rsvd_reads_0",   1'b0, REG_RSVD, 32'h0, 32'h0};
    vecs[8]  = '{"ctrl_after_rsvd",1'b0, REG_CTRL, 32'h0, 32'h1};
    vecs[9]  = '{"wr_ctrl_3",      1'b1, REG_CTRL, 32'h3, 32'h0};
    vecs[10] = '{"ctrl_clr_self",  1'b0, REG_CTRL, 32'h0, 32'h1};
    vecs[11] = '{"wr_ctrl_0",      1'b1, REG_CTRL, 32'h0, 32'h0};
    vecs[12] = '{"ctrl_off",       1'b0, REG_CTRL, 32'h0, 32'h0};

    repeat (4) @(negedge clk);
    clr = 1'b0;
    check("rst_rx_int", {31'd0, rx_int}, 32'h0);

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].off, vecs[i].wdata);
      else begin
        bus_read(vecs[i].off, rd);
        check(vecs[i].name, rd, vecs[i].exp);
      end
    end

    // single frame
    send_frame(8'h55, 1'b1);
    bus_read(REG_STAT, rd); check("t1_stat", rd, 32'h0000_0101);
    bus_read(REG_DATA, rd); check("t1_data", rd, 32'h0000_0055);
    bus_read(REG_STAT, rd); check("t1_stat_empty", rd, 32'h0);

    // overrun: 17 frames, last one dropped
    for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1);
    bus_read(REG_STAT, rd); check("t2_stat_full", rd, 32'h0000_100B);
    for (int i = 0; i < 16; i++) begin
      bus_read(REG_DATA, rd);
      check($sformatf("t2_data_%0d", i), rd, 32'(i));
    end
    bus_read(REG_STAT, rd); check("t2_stat_ovr", rd, 32'h0000_0008);
    bus_write(REG_CTRL, 32'h2);
    bus_read(REG_STAT, rd); check("t2_stat_cleared", rd, 32'h0);

    // framing error
    send_frame(8'hA3, 1'b0);
    repeat (4) @(negedge clk);
    bus_read(REG_STAT, rd); check("t3_stat_ferr", rd, 32'h0000_0004);
    bus_write(REG_CTRL, 32'h2);
    bus_read(REG_STAT, rd); check("t3_stat_cleared", rd, 32'h0);

    // short glitch, then a clean frame shows the receiver is idle again
    @(negedge clk);
    rxd = 1'b0;
    repeat (5) @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    bus_read(REG_STAT, rd); check("t4_stat_glitch", rd, 32'h0);
    send_frame(8'h96, 1'b1);
    bus_read(REG_DATA, rd); check("t4_data_after", rd, 32'h0000_0096);

    // interrupt
    bus_write(REG_CTRL, 32'h1);
    check("t5_int_idle", {31'd0, rx_int}, 32'h0);
    rise_at = -1;
    fork
      send_frame(8'h7E, 1'b1);
      for (int c = 1; c <= 170; c++) begin
        @(negedge clk);
        if (rx_int && rise_at < 0) rise_at = c;
      end
    join
    check("t5_int_rise_cycle", 32'(rise_at >= 150 && rise_at <= 160), 32'h1);
    check("t5_int_high", {31'd0, rx_int}, 32'h1);
    bus_read(REG_DATA, rd); check("t5_data", rd, 32'h0000_007E);
    @(negedge clk);
    check("t5_int_low", {31'd0, rx_int}, 32'h0);
    bus_write(REG_CTRL, 32'h0);

    // reset mid-frame
    send_frame(8'h11, 1'b1);
    @(negedge clk);
    rxd = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rxd = (i == 0 || i == 2) ? 1'b1 : 1'b0;
      repeat (16) @(negedge clk);
    end
    rxd = 1'b0;
    repeat (8) @(negedge clk);
    clr = 1'b1;
    rxd = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (20) @(negedge clk);
    bus_read(REG_STAT, rd); check("t6_stat_after_clr", rd, 32'h0);
    send_frame(8'h3C, 1'b1);
    bus_read(REG_STAT, rd); check("t6_stat_one", rd, 32'h0000_0101);

    // pop lands on the same edge as the next push
    fork
      send_frame(8'h5A, 1'b1);
      begin
        repeat (154) @(negedge clk);
        bus_read(REG_DATA, rd);
      end
    join
    check("t6_data_concurrent", rd, 32'h0000_003C);
    bus_read(REG_STAT, rd); check("t6_stat_unchanged", rd, 32'h0000_0101);
    bus_read(REG_DATA, rd); check("t6_data_next", rd, 32'h0000_005A);
    bus_read(REG_STAT, rd); check("t6_stat_final", rd, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
